// File: rtl/vx_fetch_pkg.sv
// Shared types and sizing constants for the fetch instruction buffer.
// Widths of the per-lane counters default to the standard 4-deep, 2-pop configuration.
package vx_fetch_pkg;
  localparam int UUID_WIDTH  = 44;
  localparam int NW_WIDTH    = 2;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        PC;
    logic [31:0]            instr;
  } fetch_data_t;

  localparam int FETCH_DATA_WIDTH = $bits(fetch_data_t);

  localparam int IBUF_DEPTH     = 4;
  localparam int IBUF_POP_WIDTH = 2;
  localparam int CNT_W          = $clog2(IBUF_DEPTH + 1);
  localparam int POP_W          = $clog2(IBUF_POP_WIDTH + 1);
endpackage

// File: rtl/vx_fetch_ibuf_lane.sv
// Single-lane circular FIFO exposing its oldest POP_WIDTH entries,
// with multi-pop (clamped to occupancy), flush and a registered pop count.
module vx_fetch_ibuf_lane
  import vx_fetch_pkg::*;
#(
  parameter int DEPTH      = IBUF_DEPTH,
  parameter int POP_WIDTH  = IBUF_POP_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [DATA_WIDTH-1:0]                in_data,
  output logic                                 in_ready,
  output logic [POP_WIDTH-1:0]                 out_valid,
  output logic [POP_WIDTH-1:0][DATA_WIDTH-1:0] out_data,
  input  logic [$clog2(POP_WIDTH+1)-1:0]       pop_cnt,
  input  logic                                 flush,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic [$clog2(POP_WIDTH+1)-1:0]       pop_ret
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(POP_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         head, tail;
  logic [CW-1:0]         cnt_q, pop_ext, pe;
  logic [PW-1:0]         pop_q;
  logic                  push;

  // in_ready looks only at the count register, so a full lane refuses
  // a push even when a pop frees a slot in the same cycle.
  assign in_ready = (cnt_q != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop_ext  = CW'(pop_cnt);
  assign pe       = (pop_ext > cnt_q) ? cnt_q : pop_ext;
  assign count    = cnt_q;
  assign pop_ret  = pop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      pop_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      cnt_q <= '0;
      pop_q <= '0;
    end else begin
      head  <= head + AW'(pe);
      tail  <= tail + AW'(push);
      cnt_q <= cnt_q + CW'(push) - pe;
      pop_q <= PW'(pe);
    end
  end

  // Storage is not reset; a write during flush is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush)
      assert (pop_ext <= cnt_q)
      else $warning("vx_fetch_ibuf_lane: pop_cnt %0d exceeds occupancy %0d, clamped", pop_ext, cnt_q);
  end

  for (genvar k = 0; k < POP_WIDTH; k++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx          = head + AW'(k);
    assign out_valid[k] = (cnt_q > CW'(k));
    assign out_data[k]  = mem[idx];
  end
endmodule

// File: rtl/vx_fetch_ibuf.sv
// Multi-lane instruction buffer between fetch and issue: one independent
// multi-read FIFO per schedule lane; this level only slices the buses.
module vx_fetch_ibuf
  import vx_fetch_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int DEPTH      = IBUF_DEPTH,
  parameter int POP_WIDTH  = IBUF_POP_WIDTH,
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [LANES-1:0]                                in_valid,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]                in_data,
  output logic [LANES-1:0]                                in_ready,
  output logic [LANES-1:0][POP_WIDTH-1:0]                 out_valid,
  output logic [LANES-1:0][POP_WIDTH-1:0][DATA_WIDTH-1:0] out_data,
  input  logic [LANES-1:0][$clog2(POP_WIDTH+1)-1:0]       pop_cnt,
  input  logic [LANES-1:0]                                flush,
  output logic [LANES-1:0][$clog2(DEPTH+1)-1:0]           count,
  output logic [LANES-1:0][$clog2(POP_WIDTH+1)-1:0]       pop_ret
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vx_fetch_ibuf_lane #(
      .DEPTH      (DEPTH),
      .POP_WIDTH  (POP_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[l]),
      .in_data   (in_data[l]),
      .in_ready  (in_ready[l]),
      .out_valid (out_valid[l]),
      .out_data  (out_data[l]),
      .pop_cnt   (pop_cnt[l]),
      .flush     (flush[l]),
      .count     (count[l]),
      .pop_ret   (pop_ret[l])
    );
  end
endmodule

// File: tb/tb_vx_fetch_ibuf.sv
// Directed bench for vx_fetch_ibuf (2 lanes, depth 4, pop width 2) with a
// queue scoreboard per lane: pushes enqueue, pops compare the exposed head data.
module tb_vx_fetch_ibuf;
  import vx_fetch_pkg::*;

  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int POPW  = 2;
  localparam int DW    = FETCH_DATA_WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic [LANES-1:0]                    in_valid;
  logic [LANES-1:0][DW-1:0]            in_data;
  logic [LANES-1:0]                    in_ready;
  logic [LANES-1:0][POPW-1:0]          out_valid;
  logic [LANES-1:0][POPW-1:0][DW-1:0]  out_data;
  logic [LANES-1:0][1:0]               pop_cnt;
  logic [LANES-1:0]                    flush;
  logic [LANES-1:0][2:0]               count;
  logic [LANES-1:0][1:0]               pop_ret;

  vx_fetch_ibuf #(.LANES(LANES), .DEPTH(DEPTH), .POP_WIDTH(POPW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .pop_cnt(pop_cnt), .flush(flush),
    .count(count), .pop_ret(pop_ret)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q [LANES][$];
  int exp_pr [LANES];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pkt(input int n);
    fetch_data_t p;
    p.uuid  = 44'(n * 7 + 1);
    p.wid   = 2'(n);
    p.tmask = 4'hF ^ 4'(n);
    p.PC    = 32'h1000 + 32'(n * 4);
    p.instr = 32'hABC0_0000 | 32'(n);
    return p;
  endfunction

  task automatic clear_inputs();
    in_valid = '0;
    in_data  = '0;
    pop_cnt  = '0;
    flush    = '0;
  endtask

  task automatic check_state(input string step);
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("%s count l%0d", step, l), 128'(count[l]), 128'(q[l].size()));
      chk($sformatf("%s in_ready l%0d", step, l), 128'(in_ready[l]), 128'(q[l].size() != DEPTH));
      chk($sformatf("%s pop_ret l%0d", step, l), 128'(pop_ret[l]), 128'(exp_pr[l]));
      for (int k = 0; k < POPW; k++) begin
        chk($sformatf("%s out_valid l%0d k%0d", step, l, k), 128'(out_valid[l][k]), 128'(q[l].size() > k));
        if (q[l].size() > k)
          chk($sformatf("%s out_data l%0d k%0d", step, l, k), 128'(out_data[l][k]), 128'(q[l][k]));
      end
    end
  endtask

  // Inputs are already driven; compare popped data against the scoreboard,
  // clock once, update the model, then check all visible state.
  task automatic cycle(input string step);
    int  pe  [LANES];
    bit  psh [LANES];
    for (int l = 0; l < LANES; l++) begin
      psh[l] = in_valid[l] && (q[l].size() != DEPTH);
      pe[l]  = (int'(pop_cnt[l]) > q[l].size()) ? q[l].size() : int'(pop_cnt[l]);
      if (!flush[l])
        for (int k = 0; k < pe[l]; k++)
          chk($sformatf("%s popped l%0d k%0d", step, l, k), 128'(out_data[l][k]), 128'(q[l][k]));
    end
    @(posedge clk);
    for (int l = 0; l < LANES; l++) begin
      if (flush[l]) begin
        q[l].delete();
        exp_pr[l] = 0;
      end else begin
        for (int k = 0; k < pe[l]; k++) void'(q[l].pop_front());
        if (psh[l]) q[l].push_back(in_data[l]);
        exp_pr[l] = pe[l];
      end
    end
    @(negedge clk);
    check_state(step);
    clear_inputs();
  endtask

  task automatic push0(input int n, input int pop);
    in_valid[0] = 1'b1;
    in_data[0]  = pkt(n);
    pop_cnt[0]  = 2'(pop);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    for (int l = 0; l < LANES; l++) exp_pr[l] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset in_ready", 128'(in_ready), 128'(2'b11));
    chk("reset out_valid", 128'(out_valid), 128'(0));
    chk("reset count", 128'(count), 128'(0));
    chk("reset pop_ret", 128'(pop_ret), 128'(0));
    check_state("idle");

    // Fill lane 0 with A..D.
    for (int n = 1; n <= 4; n++) begin
      push0(n, 0);
      cycle("fill");
    end
    chk("full count", 128'(count[0]), 128'(4));
    chk("full in_ready", 128'(in_ready[0]), 128'(0));

    // Pop 2: C,D become the head window.
    pop_cnt[0] = 2'd2;
    cycle("pop2");
    chk("pop2 head", 128'(out_data[0][0]), 128'(pkt(3)));
    chk("pop2 head+1", 128'(out_data[0][1]), 128'(pkt(4)));
    chk("pop2 pop_ret", 128'(pop_ret[0]), 128'(2));

    // Push E at index 0 while popping C: head=3, window straddles 3->0.
    push0(5, 1);
    cycle("pre-wrap");
    chk("straddle head", 128'(out_data[0][0]), 128'(pkt(4)));
    chk("straddle head+1", 128'(out_data[0][1]), 128'(pkt(5)));
    // Pop D,E across the wrap and push F into index 1.
    push0(6, 2);
    cycle("wrap pop");
    chk("wrap push F", 128'(out_data[0][0]), 128'(pkt(6)));
    chk("wrap count", 128'(count[0]), 128'(1));

    // Refill to full, then push with a pop: push refused.
    for (int n = 7; n <= 9; n++) begin
      push0(n, 0);
      cycle("refill");
    end
    push0(10, 1);
    cycle("full push+pop");
    chk("refused count", 128'(count[0]), 128'(3));
    chk("refused head", 128'(out_data[0][0]), 128'(pkt(7)));

    // Drop to 2, then flush colliding with push and pop.
    pop_cnt[0] = 2'd1;
    cycle("to two");
    push0(11, 1);
    flush[0] = 1'b1;
    cycle("flush collide");
    chk("flush count", 128'(count[0]), 128'(0));
    chk("flush out_valid", 128'(out_valid[0]), 128'(0));
    chk("flush pop_ret", 128'(pop_ret[0]), 128'(0));

    // Lane independence: flush lane 0 while lane 1 pushes.
    push0(12, 0);
    cycle("lane0 push");
    flush[0]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = pkt(13);
    cycle("indep");
    chk("indep lane1 count", 128'(count[1]), 128'(1));
    chk("indep lane0 count", 128'(count[0]), 128'(0));

    // Push+pop at count 1 keeps the new entry only.
    in_valid[1] = 1'b1;
    in_data[1]  = pkt(14);
    pop_cnt[1]  = 2'd1;
    cycle("push+pop at 1");
    chk("pp1 count", 128'(count[1]), 128'(1));
    chk("pp1 head", 128'(out_data[1][0]), 128'(pkt(14)));

    // Illegal pop of 2 at count 1 is clamped to 1.
    pop_cnt[1] = 2'd2;
    cycle("illegal pop");
    chk("clamp pop_ret", 128'(pop_ret[1]), 128'(1));
    chk("clamp count", 128'(count[1]), 128'(0));

    // Reset mid-operation empties every lane.
    push0(15, 0);
    cycle("pre-reset");
    reset = 1'b1;
    @(posedge clk);
    for (int l = 0; l < LANES; l++) begin
      q[l].delete();
      exp_pr[l] = 0;
    end
    @(negedge clk);
    reset = 1'b0;
    check_state("mid reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
